bmp180_target: RTL

//  I2C target (responder) that emulates the BMP180 pressure sensor at byte/register level.
//  It watches an oversampled SCL/SDA pair and answers the register write/read transactions

---
 rtl/bmp180_target.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bmp180_target.sv
// BMP180 I2C target emulator: filtered SCL/SDA front end plus a byte-level register FSM
// serving chip ID, ctrl_meas and a coherent shadow of the 24-bit measurement.
module bmp180_target #(
    parameter logic [6:0]  ADR     = 7'h77,
    parameter logic [7:0]  CHIP_ID = 8'h55,
    parameter int unsigned FILTER  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [23:0] sample,
    output logic [7:0]  ctrl_meas,
    output logic        ctrl_wr,
    output logic        busy,
    output logic [3:0]  stateOut
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WRITE     = 4'd5,
        WRITE_ACK = 4'd6,
        READ      = 4'd7,
        IGNORE    = 4'd8,
        RD_ACK    = 4'd9
    } state_t;

    // Index 1 = SCL, index 0 = SDA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1  <= {scl, sda_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i])
                    cnt[i] <= '0;
                else if (cnt[i] == CW'(FILTER - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    logic fscl, fsda, scl_rise, scl_fall, start_c, stop_c;
    assign fscl     = filt[1];
    assign fsda     = filt[0];
    assign scl_rise =  fscl & ~filt_d[1];
    assign scl_fall = ~fscl &  filt_d[1];
    assign start_c  =  fscl & ~fsda &  filt_d[0];
    assign stop_c   =  fscl &  fsda & ~filt_d[0];

    function automatic logic [7:0] rd_reg(input logic [7:0] a, input logic [23:0] sh,
                                          input logic [7:0] cm);
        case (a)
            8'hD0:   return CHIP_ID;
            8'hF4:   return cm;
            8'hF6:   return sh[23:16];
            8'hF7:   return sh[15:8];
            8'hF8:   return sh[7:0];
            default: return 8'h00;
        endcase
    endfunction

    state_t      state;
    logic [7:0]  shift, ptr;
    logic [3:0]  bitcnt;
    logic        rw;
    logic [23:0] shadow;

    assign stateOut = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            ptr       <= '0;
            bitcnt    <= '0;
            rw        <= 1'b0;
            shadow    <= '0;
            sda_oe    <= 1'b0;
            ctrl_meas <= '0;
            ctrl_wr   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ctrl_wr <= 1'b0;
            if (start_c) begin
                state  <= ADDR;
                bitcnt <= '0;
                busy   <= 1'b1;
                sda_oe <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                bitcnt <= '0;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift  <= {shift[6:0], fsda};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            if (shift[7:1] == ADR) begin
                                sda_oe <= 1'b1;
                                rw     <= shift[0];
                                state  <= ADDR_ACK;
                                // Shadow captured once here keeps a whole burst coherent
                                if (shift[0]) begin
                                    shadow <= sample;
                                    shift  <= rd_reg(ptr, sample, ctrl_meas);
                                end
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                sda_oe <= ~shift[7];
                                bitcnt <= 4'd1;
                                state  <= READ;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= REG;
                            end
                        end
                    end
                    REG: begin
                        if (scl_rise) begin
                            shift  <= {shift[6:0], fsda};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            sda_oe <= 1'b1;
                            state  <= REG_ACK;
                        end
                    end
                    REG_ACK: begin
                        if (scl_fall) begin
                            ptr    <= shift;
                            sda_oe <= 1'b0;
                            state  <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift  <= {shift[6:0], fsda};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            sda_oe <= 1'b1;
                            state  <= WRITE_ACK;
                            if (ptr == 8'hF4) begin
                                ctrl_meas <= shift;
                                ctrl_wr   <= 1'b1;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            ptr    <= ptr + 8'd1;
                            sda_oe <= 1'b0;
                            state  <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            if (bitcnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                                bitcnt <= bitcnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // NACK leaves on the rising edge, so a falling edge here means ACK
                        if (scl_rise) begin
                            if (!fsda) begin
                                ptr   <= ptr + 8'd1;
                                shift <= rd_reg(ptr + 8'd1, shadow, ctrl_meas);
                            end else
                                state <= IGNORE;
                        end else if (scl_fall) begin
                            sda_oe <= ~shift[7];
                            bitcnt <= 4'd1;
                            state  <= READ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
